// File: rtl/yuv_to_rgb_csc_stream.sv
// yuv_to_rgb_csc_stream: 5-stage YUV->RGB colour-space converter with
// valid/ready flow control and per-frame matrix selection.
//
// Ports:
//   i_sysclk, i_arst         clock, synchronous active-high reset
//   i_mode                   0=601 limited, 1=601 full, 2=709 limited, 3=bypass
//                            (latched on an accepted SOF beat)
//   i_valid/o_ready          input handshake
//   i_sof/i_eol              frame / line markers, travel with the pixel
//   i_Y/i_U/i_V              unsigned input components
//   o_valid/i_ready          output handshake
//   o_sof/o_eol              delayed markers
//   o_R/o_G/o_B              clamped unsigned result
//
// Pipeline: S1 offsets, S2 coefficient select, S3 products,
// S4 sum/round/shift, S5 clamp (output registers).
module yuv_to_rgb_csc_stream #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 8,
    parameter int COEF_FRAC = 8
) (
    input  logic             i_sysclk,
    input  logic             i_arst,
    input  logic [1:0]       i_mode,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sof,
    input  logic             i_eol,
    input  logic [IN_W-1:0]  i_Y,
    input  logic [IN_W-1:0]  i_U,
    input  logic [IN_W-1:0]  i_V,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sof,
    output logic             o_eol,
    output logic [OUT_W-1:0] o_R,
    output logic [OUT_W-1:0] o_G,
    output logic [OUT_W-1:0] o_B
);

    localparam int K  = IN_W - 8;
    localparam int DW = IN_W + 1;
    localparam int CW = 11;
    localparam int PW = DW + CW;
    localparam int SW = IN_W + 13;
    localparam int SH = COEF_FRAC + IN_W - OUT_W;
    localparam int BW = 3 * OUT_W;

    localparam logic signed [DW-1:0] Y_OFS = DW'(16 << K);
    localparam logic signed [DW-1:0] C_OFS = DW'(128 << K);
    localparam logic signed [SW-1:0] RND   = SW'(1 << (SH - 1));
    localparam logic signed [SW-1:0] MAXV  = SW'((1 << OUT_W) - 1);

    function automatic logic [OUT_W-1:0] clamp(input logic signed [SW-1:0] x);
        if (x < 0)
            return '0;
        else if (x > MAXV)
            return '1;
        else
            return x[OUT_W-1:0];
    endfunction

    logic ce;
    logic [1:0] mode_q;
    logic [1:0] beat_mode;
    logic [3:0] v_q;
    logic [3:0] sof_q;
    logic [3:0] eol_q;

    // S1
    logic signed [DW-1:0] y_ext;
    logic [1:0]           s1_mode;
    logic signed [DW-1:0] s1_c, s1_d, s1_e;
    logic [BW-1:0]        s1_byp;

    // S2
    logic signed [CW-1:0] ky, rv, gu, gv, bu;
    logic signed [CW-1:0] s2_ky, s2_rv, s2_gu, s2_gv, s2_bu;
    logic signed [DW-1:0] s2_c, s2_d, s2_e;
    logic                 s2_bypass;
    logic [BW-1:0]        s2_byp;

    // S3
    logic signed [PW-1:0] s3_yc, s3_rv, s3_gu, s3_gv, s3_bu;
    logic                 s3_bypass;
    logic [BW-1:0]        s3_byp;

    // S4
    logic signed [SW-1:0] sum_r, sum_g, sum_b;
    logic signed [SW-1:0] s4_r, s4_g, s4_b;
    logic                 s4_bypass;
    logic [BW-1:0]        s4_byp;

    // Every stage moves in lock-step; the only stall source is the
    // output register being full while downstream refuses it.
    assign ce      = ~o_valid | i_ready;
    assign o_ready = ce;

    // An SOF beat uses its own i_mode immediately; later beats of the
    // frame reuse the latched value, so mid-frame mode changes are inert.
    assign beat_mode = i_sof ? i_mode : mode_q;
    assign y_ext     = signed'({1'b0, i_Y});

    always_comb begin
        ky = '0;
        rv = '0;
        gu = '0;
        gv = '0;
        bu = '0;
        unique case (s1_mode)
            2'd0: begin
                ky = 11'sd298;
                rv = 11'sd409;
                gu = -11'sd100;
                gv = -11'sd208;
                bu = 11'sd516;
            end
            2'd1: begin
                ky = 11'sd256;
                rv = 11'sd359;
                gu = -11'sd88;
                gv = -11'sd183;
                bu = 11'sd454;
            end
            2'd2: begin
                ky = 11'sd298;
                rv = 11'sd459;
                gu = -11'sd55;
                gv = -11'sd136;
                bu = 11'sd541;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        sum_r = SW'(s3_yc) + SW'(s3_rv) + RND;
        sum_g = SW'(s3_yc) + SW'(s3_gu) + SW'(s3_gv) + RND;
        sum_b = SW'(s3_yc) + SW'(s3_bu) + RND;
    end

    // Control path: valids, markers, mode and output registers.
    always_ff @(posedge i_sysclk) begin
        if (i_arst) begin
            mode_q  <= 2'd0;
            v_q     <= '0;
            sof_q   <= '0;
            eol_q   <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eol   <= 1'b0;
            o_R     <= '0;
            o_G     <= '0;
            o_B     <= '0;
        end else if (ce) begin
            if (i_valid && i_sof)
                mode_q <= i_mode;
            v_q     <= {v_q[2:0], i_valid};
            sof_q   <= {sof_q[2:0], i_sof & i_valid};
            eol_q   <= {eol_q[2:0], i_eol & i_valid};
            o_valid <= v_q[3];
            o_sof   <= sof_q[3];
            o_eol   <= eol_q[3];
            if (s4_bypass) begin
                o_R <= s4_byp[BW-1 -: OUT_W];
                o_G <= s4_byp[2*OUT_W-1 -: OUT_W];
                o_B <= s4_byp[OUT_W-1:0];
            end else begin
                o_R <= clamp(s4_r);
                o_G <= clamp(s4_g);
                o_B <= clamp(s4_b);
            end
        end
    end

    // Datapath: no reset needed, qualified by the valid pipe.
    always_ff @(posedge i_sysclk) begin
        if (ce) begin
            s1_mode <= beat_mode;
            s1_c    <= (beat_mode == 2'd1) ? y_ext : y_ext - Y_OFS;
            s1_d    <= signed'({1'b0, i_U}) - C_OFS;
            s1_e    <= signed'({1'b0, i_V}) - C_OFS;
            s1_byp  <= {i_Y[IN_W-1 -: OUT_W],
                        i_U[IN_W-1 -: OUT_W],
                        i_V[IN_W-1 -: OUT_W]};

            s2_ky     <= ky;
            s2_rv     <= rv;
            s2_gu     <= gu;
            s2_gv     <= gv;
            s2_bu     <= bu;
            s2_c      <= s1_c;
            s2_d      <= s1_d;
            s2_e      <= s1_e;
            s2_bypass <= (s1_mode == 2'd3);
            s2_byp    <= s1_byp;

            s3_yc     <= PW'(s2_ky) * PW'(s2_c);
            s3_rv     <= PW'(s2_rv) * PW'(s2_e);
            s3_gu     <= PW'(s2_gu) * PW'(s2_d);
            s3_gv     <= PW'(s2_gv) * PW'(s2_e);
            s3_bu     <= PW'(s2_bu) * PW'(s2_d);
            s3_bypass <= s2_bypass;
            s3_byp    <= s2_byp;

            s4_r      <= sum_r >>> SH;
            s4_g      <= sum_g >>> SH;
            s4_b      <= sum_b >>> SH;
            s4_bypass <= s3_bypass;
            s4_byp    <= s3_byp;
        end
    end

endmodule
